// File: rtl/hazard_scoreboard_if.sv
// Decode <-> hazard scoreboard bundle: ID-stage instruction fields in, stall/status out.
interface hazard_scoreboard_if #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned RA_W     = 4
);
  logic                id_valid;
  logic [RA_W-1:0]     id_rs1;
  logic [RA_W-1:0]     id_rs2;
  logic [RA_W-1:0]     id_rd;
  logic                id_rs1_used;
  logic                id_rs2_used;
  logic                id_rd_wr;
  logic                id_is_load;
  logic                id_is_mc;
  logic                id_is_ctrl;
  logic                fwd_r1_en;
  logic                fwd_r2_en;
  logic                flush;
  logic                if_id_stall;
  logic                id_ex_stall;
  logic                mc_busy;
  logic [NUM_REGS-1:0] sb_pending;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_rs1_used, id_rs2_used, id_rd_wr,
           id_is_load, id_is_mc, id_is_ctrl, fwd_r1_en, fwd_r2_en, flush,
    input  if_id_stall, id_ex_stall, mc_busy, sb_pending
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_rs1_used, id_rs2_used, id_rd_wr,
           id_is_load, id_is_mc, id_is_ctrl, fwd_r1_en, fwd_r2_en, flush,
    output if_id_stall, id_ex_stall, mc_busy, sb_pending
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Latency-aware ID-stage hazard scoreboard with multi-cycle ALU timer and control bubbles.
// Define HAZARD_WAW_EN to also stall writes that would retire before an older in-flight write.
module hazard_scoreboard #(
  parameter int unsigned NUM_REGS     = 16,
  parameter int unsigned RA_W         = 4,
  parameter int unsigned ALU_LAT      = 3,
  parameter int unsigned LD_LAT       = 3,
  parameter int unsigned LD_FWD_CNT   = 2,
  parameter int unsigned MC_LAT       = 4,
  parameter int unsigned CTRL_BUBBLES = 1,
  parameter int unsigned CNT_W        = 3
) (
  input logic               clk,
  input logic               rst_n,
  hazard_scoreboard_if.slave bus
);

  localparam logic [CNT_W-1:0] AluLat      = CNT_W'(ALU_LAT);
  localparam logic [CNT_W-1:0] LdLat       = CNT_W'(LD_LAT);
  localparam logic [CNT_W-1:0] McLat       = CNT_W'(MC_LAT);
  localparam logic [CNT_W-1:0] CtrlBubbles = CNT_W'(CTRL_BUBBLES);
  localparam logic [CNT_W-1:0] LdFwdCnt    = CNT_W'(LD_FWD_CNT);

  // r0 and out-of-range indices never take part in tracking or hazards.
  function automatic logic tracked(input logic [RA_W-1:0] r);
    return (r != '0) && (32'(r) < NUM_REGS);
  endfunction

  function automatic logic [CNT_W-1:0] dec(input logic [CNT_W-1:0] c);
    return (c != '0) ? c - 1'b1 : '0;
  endfunction

  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] ld_q, ld_d;
  logic [CNT_W-1:0]    mc_cnt_q, mc_cnt_d;
  logic [CNT_W-1:0]    ctrl_cnt_q, ctrl_cnt_d;
  logic [CNT_W-1:0]    new_lat;
  logic                haz_rs1, haz_rs2, haz_waw;
  logic                issue;
  logic [NUM_REGS-1:0] pending;

  always_comb begin
    new_lat = bus.id_is_load ? LdLat : (bus.id_is_mc ? McLat : AluLat);
  end

  always_comb begin : hazard_check
    haz_rs1 = 1'b0;
    haz_rs2 = 1'b0;
    haz_waw = 1'b0;
    // A load result only reaches the forward net once it is close enough to writeback.
    if (bus.id_rs1_used && tracked(bus.id_rs1) && (cnt_q[bus.id_rs1] != '0)) begin
      haz_rs1 = !bus.fwd_r1_en || (ld_q[bus.id_rs1] && (cnt_q[bus.id_rs1] > LdFwdCnt));
    end
    if (bus.id_rs2_used && tracked(bus.id_rs2) && (cnt_q[bus.id_rs2] != '0)) begin
      haz_rs2 = !bus.fwd_r2_en || (ld_q[bus.id_rs2] && (cnt_q[bus.id_rs2] > LdFwdCnt));
    end
`ifdef HAZARD_WAW_EN
    if (bus.id_rd_wr && tracked(bus.id_rd)) begin
      haz_waw = cnt_q[bus.id_rd] > new_lat;
    end
`endif
  end

  assign bus.mc_busy     = (mc_cnt_q != '0);
  assign bus.id_ex_stall = bus.mc_busy | (bus.id_valid & (haz_rs1 | haz_rs2 | haz_waw));
  assign bus.if_id_stall = bus.id_ex_stall | (bus.id_valid & bus.id_is_ctrl) |
                           (ctrl_cnt_q != '0);
  assign issue           = bus.id_valid & ~bus.id_ex_stall;

  always_comb begin
    pending = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      pending[i] = (cnt_q[i] != '0);
    end
  end
  assign bus.sb_pending = pending;

  always_comb begin : next_state
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_d[i] = dec(cnt_q[i]);
    end
    ld_d       = ld_q;
    mc_cnt_d   = dec(mc_cnt_q);
    ctrl_cnt_d = dec(ctrl_cnt_q);
    if (issue && bus.id_rd_wr && tracked(bus.id_rd)) begin
      cnt_d[bus.id_rd] = new_lat;
      ld_d[bus.id_rd]  = bus.id_is_load;
    end
    if (issue && bus.id_is_mc) begin
      mc_cnt_d = McLat;
    end
    if (issue && bus.id_is_ctrl) begin
      ctrl_cnt_d = CtrlBubbles;
    end
    if (bus.flush) begin
      ctrl_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt_q[i] <= '0;
      end
      ld_q       <= '0;
      mc_cnt_q   <= '0;
      ctrl_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      ld_q       <= ld_d;
      mc_cnt_q   <= mc_cnt_d;
      ctrl_cnt_q <= ctrl_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus random traffic against a timestamp model.
module tb_hazard_scoreboard;

  localparam int NR = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.NUM_REGS(16), .RA_W(4)) bus ();

  hazard_scoreboard #(
    .NUM_REGS(16), .RA_W(4), .ALU_LAT(3), .LD_LAT(3), .LD_FWD_CNT(2),
    .MC_LAT(4), .CTRL_BUBBLES(1), .CNT_W(3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: absolute cycle at which each resource becomes free; remaining = at - now.
  int cyc = 0;
  int wb_at [NR];
  bit ld_flag [NR];
  int mc_at = 0;
  int ctrl_at = 0;

  logic          e_ifid, e_idex, e_mc;
  logic [NR-1:0] e_pend;

  function automatic int rem(int at);
    return (at > cyc) ? at - cyc : 0;
  endfunction

  function automatic int lat_of(logic is_load, logic is_mc);
    return is_load ? 3 : (is_mc ? 4 : 3);
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < NR; r++) begin
      wb_at[r] = 0;
      ld_flag[r] = 1'b0;
    end
    mc_at = 0;
    ctrl_at = 0;
  endfunction

  function automatic void model_eval();
    bit h1, h2, waw;
    int r1, r2;
    r1 = rem(wb_at[bus.id_rs1]);
    r2 = rem(wb_at[bus.id_rs2]);
    h1 = bus.id_rs1_used && (bus.id_rs1 != 0) && (r1 != 0) &&
         (!bus.fwd_r1_en || (ld_flag[bus.id_rs1] && r1 > 2));
    h2 = bus.id_rs2_used && (bus.id_rs2 != 0) && (r2 != 0) &&
         (!bus.fwd_r2_en || (ld_flag[bus.id_rs2] && r2 > 2));
    waw = 1'b0;
`ifdef HAZARD_WAW_EN
    waw = bus.id_rd_wr && (bus.id_rd != 0) &&
          (rem(wb_at[bus.id_rd]) > lat_of(bus.id_is_load, bus.id_is_mc));
`endif
    e_mc   = rem(mc_at) != 0;
    e_idex = e_mc || (bus.id_valid && (h1 || h2 || waw));
    e_ifid = e_idex || (bus.id_valid && bus.id_is_ctrl) || (rem(ctrl_at) != 0);
    for (int r = 0; r < NR; r++) e_pend[r] = rem(wb_at[r]) != 0;
  endfunction

  task automatic idle();
    bus.id_valid = 1'b0; bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rd = '0;
    bus.id_rs1_used = 1'b0; bus.id_rs2_used = 1'b0; bus.id_rd_wr = 1'b0;
    bus.id_is_load = 1'b0; bus.id_is_mc = 1'b0; bus.id_is_ctrl = 1'b0;
    bus.fwd_r1_en = 1'b0; bus.fwd_r2_en = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  // Advance one clock; the model retires the instruction it believes issued.
  task automatic tick();
    bit iss;
    model_eval();
    iss = bus.id_valid && !e_idex;
    @(posedge clk);
    if (iss && bus.id_rd_wr && bus.id_rd != 0) begin
      wb_at[bus.id_rd] = cyc + 1 + lat_of(bus.id_is_load, bus.id_is_mc);
      ld_flag[bus.id_rd] = bus.id_is_load;
    end
    if (iss && bus.id_is_mc) mc_at = cyc + 1 + 4;
    if (bus.flush) ctrl_at = 0;
    else if (iss && bus.id_is_ctrl) ctrl_at = cyc + 1 + 1;
    cyc++;
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (6) tick();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #2;
    checks++; if (bus.if_id_stall !== 1'b0) begin errors++;
      $display("FAIL reset_if_id_stall: got %b want 0", bus.if_id_stall); end
    checks++; if (bus.id_ex_stall !== 1'b0) begin errors++;
      $display("FAIL reset_id_ex_stall: got %b want 0", bus.id_ex_stall); end
    checks++; if (bus.mc_busy !== 1'b0) begin errors++;
      $display("FAIL reset_mc_busy: got %b want 0", bus.mc_busy); end
    checks++; if (bus.sb_pending !== 16'h0) begin errors++;
      $display("FAIL reset_sb_pending: got %h want 0000", bus.sb_pending); end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_alu_forward();
    int n;
    idle(); bus.id_valid = 1'b1; bus.id_rd = 4'd5; bus.id_rd_wr = 1'b1;
    settle();
    checks++; if (bus.id_ex_stall !== 1'b0) begin errors++;
      $display("FAIL alu_issue: id_ex_stall got %b want 0", bus.id_ex_stall); end
    tick();
    idle(); bus.id_valid = 1'b1; bus.id_rs1 = 4'd5; bus.id_rs1_used = 1'b1;
    bus.fwd_r1_en = 1'b1;
    settle();
    checks++; if (bus.id_ex_stall !== 1'b0) begin errors++;
      $display("FAIL alu_fwd_on: id_ex_stall got %b want 0", bus.id_ex_stall); end
    bus.fwd_r1_en = 1'b0;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      settle();
      checks++; if (bus.id_ex_stall !== e_idex || bus.if_id_stall !== e_ifid) begin errors++;
        $display("FAIL alu_fwd_off_cyc%0d: stalls got %b%b want %b%b", k,
                 bus.if_id_stall, bus.id_ex_stall, e_ifid, e_idex); end
      if (bus.id_ex_stall !== 1'b1) break;
      n++;
      tick();
    end
    checks++; if (n != 3) begin errors++;
      $display("FAIL alu_fwd_off_len: stall cycles got %0d want 3", n); end
    tick();
  endtask

  task automatic test_load_use();
    int n;
    idle(); bus.id_valid = 1'b1; bus.id_rd = 4'd3; bus.id_rd_wr = 1'b1; bus.id_is_load = 1'b1;
    tick();
    idle(); bus.id_valid = 1'b1; bus.id_rs2 = 4'd3; bus.id_rs2_used = 1'b1;
    bus.fwd_r2_en = 1'b1;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      settle();
      checks++; if (bus.id_ex_stall !== e_idex || bus.sb_pending !== e_pend) begin errors++;
        $display("FAIL load_use_cyc%0d: id_ex_stall %b/%b pending %h/%h", k,
                 bus.id_ex_stall, e_idex, bus.sb_pending, e_pend); end
      if (bus.id_ex_stall !== 1'b1) break;
      n++;
      tick();
    end
    checks++; if (n != 1) begin errors++;
      $display("FAIL load_use_len: stall cycles got %0d want 1", n); end
    tick();
  endtask

  task automatic test_mc();
    int n;
    drain();
    bus.id_valid = 1'b1; bus.id_rd = 4'd7; bus.id_rd_wr = 1'b1; bus.id_is_mc = 1'b1;
    tick();
    idle(); bus.id_valid = 1'b1; bus.id_rd = 4'd8; bus.id_rd_wr = 1'b1;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      settle();
      checks++; if (bus.mc_busy !== e_mc || bus.id_ex_stall !== e_idex ||
                    bus.if_id_stall !== e_ifid) begin errors++;
        $display("FAIL mc_cyc%0d: busy/ifid/idex got %b%b%b want %b%b%b", k, bus.mc_busy,
                 bus.if_id_stall, bus.id_ex_stall, e_mc, e_ifid, e_idex); end
      if (bus.id_ex_stall !== 1'b1) break;
      n++;
      tick();
    end
    checks++; if (n != 4) begin errors++;
      $display("FAIL mc_len: stall cycles got %0d want 4", n); end
    tick();
  endtask

  task automatic test_ctrl_flush();
    drain();
    bus.id_valid = 1'b1; bus.id_is_ctrl = 1'b1;
    settle();
    checks++; if (bus.if_id_stall !== 1'b1 || bus.id_ex_stall !== 1'b0) begin errors++;
      $display("FAIL ctrl_in_id: ifid/idex got %b%b want 10", bus.if_id_stall, bus.id_ex_stall); end
    tick();
    idle(); settle();
    checks++; if (bus.if_id_stall !== 1'b1) begin errors++;
      $display("FAIL ctrl_bubble: if_id_stall got %b want 1", bus.if_id_stall); end
    tick(); settle();
    checks++; if (bus.if_id_stall !== 1'b0) begin errors++;
      $display("FAIL ctrl_bubble_end: if_id_stall got %b want 0", bus.if_id_stall); end
    // Flush in the same cycle as the branch issues cancels the bubble.
    bus.id_valid = 1'b1; bus.id_is_ctrl = 1'b1; bus.flush = 1'b1;
    tick();
    idle(); settle();
    checks++; if (bus.if_id_stall !== 1'b0) begin errors++;
      $display("FAIL ctrl_flush_same: if_id_stall got %b want 0", bus.if_id_stall); end
    bus.id_valid = 1'b1; bus.id_is_ctrl = 1'b1;
    tick();
    idle(); bus.flush = 1'b1; settle();
    checks++; if (bus.if_id_stall !== 1'b1) begin errors++;
      $display("FAIL ctrl_flush_bubble: if_id_stall got %b want 1", bus.if_id_stall); end
    tick();
    idle(); settle();
    checks++; if (bus.if_id_stall !== 1'b0) begin errors++;
      $display("FAIL ctrl_flush_after: if_id_stall got %b want 0", bus.if_id_stall); end
  endtask

  task automatic test_r0_and_reset();
    idle(); bus.id_valid = 1'b1; bus.id_rd = 4'd0; bus.id_rd_wr = 1'b1;
    tick();
    idle(); bus.id_valid = 1'b1; bus.id_rs1 = 4'd0; bus.id_rs1_used = 1'b1;
    settle();
    checks++; if (bus.id_ex_stall !== 1'b0 || bus.sb_pending !== 16'h0) begin errors++;
      $display("FAIL r0_read: idex %b pending %h want 0 0000", bus.id_ex_stall, bus.sb_pending); end
    tick();
    idle(); bus.id_valid = 1'b1; bus.id_rd = 4'd9; bus.id_rd_wr = 1'b1; bus.id_is_load = 1'b1;
    tick();
    idle(); settle();
    checks++; if (bus.sb_pending !== e_pend || e_pend[9] !== 1'b1) begin errors++;
      $display("FAIL ld_pending: got %h want %h", bus.sb_pending, e_pend); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.sb_pending !== 16'h0 || bus.if_id_stall !== 1'b0) begin errors++;
      $display("FAIL async_reset: pending %h ifid %b want 0000 0", bus.sb_pending,
               bus.if_id_stall); end
    model_clear();
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_waw();
    int n;
    drain();
    bus.id_valid = 1'b1; bus.id_rd = 4'd4; bus.id_rd_wr = 1'b1; bus.id_is_mc = 1'b1;
    tick();
    idle(); bus.id_valid = 1'b1; bus.id_rd = 4'd4; bus.id_rd_wr = 1'b1;
    for (int k = 0; k < 10; k++) begin
      settle();
      checks++; if (bus.id_ex_stall !== e_idex) begin errors++;
        $display("FAIL waw_cyc%0d: id_ex_stall got %b want %b", k, bus.id_ex_stall, e_idex); end
      if (bus.id_ex_stall !== 1'b1) break;
      tick();
    end
    tick();
    idle(); bus.id_valid = 1'b1; bus.id_rs1 = 4'd4; bus.id_rs1_used = 1'b1;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      settle();
      if (bus.id_ex_stall !== 1'b1) break;
      n++;
      tick();
    end
    checks++; if (n != 3) begin errors++;
      $display("FAIL waw_overwrite_len: stall cycles got %0d want 3", n); end
    tick();
  endtask

  task automatic test_random();
    int kind;
    for (int k = 0; k < 500; k++) begin
      kind = int'($urandom_range(0, 9));
      bus.id_valid    = ($urandom_range(0, 3) != 0);
      bus.id_rs1      = 4'($urandom_range(0, 7));
      bus.id_rs2      = 4'($urandom_range(0, 7));
      bus.id_rd       = 4'($urandom_range(0, 7));
      bus.id_rs1_used = 1'($urandom_range(0, 1));
      bus.id_rs2_used = 1'($urandom_range(0, 1));
      bus.id_rd_wr    = ($urandom_range(0, 4) != 0);
      bus.id_is_load  = (kind < 3);
      bus.id_is_mc    = (kind == 3);
      bus.id_is_ctrl  = (kind == 4);
      bus.fwd_r1_en   = ($urandom_range(0, 3) != 0);
      bus.fwd_r2_en   = ($urandom_range(0, 3) != 0);
      bus.flush       = ($urandom_range(0, 7) == 0);
      settle();
      checks++; if (bus.if_id_stall !== e_ifid || bus.id_ex_stall !== e_idex ||
                    bus.mc_busy !== e_mc || bus.sb_pending !== e_pend) begin errors++;
        $display("FAIL rand_%0d: ifid/idex/busy/pend got %b%b%b %h want %b%b%b %h", k,
                 bus.if_id_stall, bus.id_ex_stall, bus.mc_busy, bus.sb_pending,
                 e_ifid, e_idex, e_mc, e_pend); end
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        #1;
        checks++; if (bus.sb_pending !== 16'h0 || bus.mc_busy !== 1'b0) begin errors++;
          $display("FAIL rand_reset_%0d: pending %h busy %b want 0000 0", k,
                   bus.sb_pending, bus.mc_busy); end
        model_clear();
        #1;
        rst_n = 1'b1;
      end
      tick();
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_alu_forward();
    test_load_use();
    test_mc();
    test_ctrl_flush();
    test_r0_and_reset();
    test_waw();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
